// File: rtl/gsim_fetch_sched_pkg.sv
// ----------------------------------------------------------------------------
// gsim_fetch_sched_pkg
// Shared definitions for the Gauss-Seidel matrix-fetch scheduler:
//   - scheduler FSM state encodings
//   - matrix geometry (WORDS_PER_MTX) and matrix-memory port widths
//   - the per-word tag carried alongside each fetched row
// ----------------------------------------------------------------------------
package gsim_fetch_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_WAIT_ENG = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    // 16 coefficient rows plus one b-vector word per matrix
    localparam int WORDS_PER_MTX = 17;
    localparam int MEM_DATA_W    = 256;
    localparam int MEM_ADDR_W    = 10;
    localparam int IDX_W         = 5;

    // Tag attached to each word when its request is accepted
    typedef struct packed {
        logic [IDX_W-1:0] mtx;
        logic [IDX_W-1:0] word;
        logic             last;
    } row_tag_t;

    localparam int TAG_W = $bits(row_tag_t);

endpackage

// File: rtl/gsim_row_fifo.sv
// ----------------------------------------------------------------------------
// gsim_row_fifo
// Small synchronous FIFO with a combinational head (the word written in cycle
// t is visible on o_rd_data in cycle t+1). DEPTH must be a power of two >= 2.
// Writes to a full FIFO and reads from an empty FIFO are ignored. The head
// reads as zero while empty so downstream sees clean outputs.
// Ports:
//   i_clk, i_reset      clock, asynchronous active-high reset
//   i_wr_en, i_wr_data  push
//   i_rd_en             pop the head
//   o_rd_data           head entry (zero when empty)
//   o_full, o_empty     status
//   o_count             current occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module gsim_row_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_wr;
    logic             do_rd;

    assign o_full    = (count_q == CNT_W'(DEPTH));
    assign o_empty   = (count_q == '0);
    assign o_count   = count_q;
    assign do_wr     = i_wr_en && !o_full;
    assign do_rd     = i_rd_en && !o_empty;
    assign o_rd_data = o_empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset: validity is tracked by the pointers alone
    always_ff @(posedge i_clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= i_wr_data;
        end
    end

endmodule

// File: rtl/gsim_fetch_sched.sv
// ----------------------------------------------------------------------------
// gsim_fetch_sched
// Matrix-fetch scheduler. On start walks matrices 0..N-1, issues reads to the
// matrix memory under a credit limit, buffers returns in gsim_row_fifo and
// streams them to the datapath with word/matrix tags. Counts per-matrix
// completions and pulses o_proc_done when all N are finished.
// Build option: define GSIM_PREFETCH_EN to start fetching matrix m+1 right
// after the last word of m is accepted; otherwise each matrix waits for the
// datapath's i_mtx_done of the previous one.
// Ports:
//   i_clk, i_reset                    clock, asynchronous active-high reset
//   i_module_en, i_matrix_num         start and matrix count (sampled in IDLE)
//   o_proc_done                       one-cycle completion pulse
//   o_mem_rreq, o_mem_addr, i_mem_rrdy           read request channel
//   i_mem_dout, i_mem_dout_vld                    in-order read returns
//   o_row_vld/data/idx/last, o_mtx_idx, i_row_rdy row stream to datapath
//   i_mtx_done                        datapath finished one matrix
// ----------------------------------------------------------------------------
module gsim_fetch_sched
    import gsim_fetch_sched_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_module_en,
    input  logic [IDX_W-1:0]      i_matrix_num,
    output logic                  o_proc_done,
    output logic                  o_mem_rreq,
    output logic [MEM_ADDR_W-1:0] o_mem_addr,
    input  logic                  i_mem_rrdy,
    input  logic [MEM_DATA_W-1:0] i_mem_dout,
    input  logic                  i_mem_dout_vld,
    output logic                  o_row_vld,
    output logic [MEM_DATA_W-1:0] o_row_data,
    output logic [IDX_W-1:0]      o_row_idx,
    output logic                  o_row_last,
    output logic [IDX_W-1:0]      o_mtx_idx,
    input  logic                  i_row_rdy,
    input  logic                  i_mtx_done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

`ifdef GSIM_PREFETCH_EN
    localparam logic PREFETCH = 1'b1;
`else
    localparam logic PREFETCH = 1'b0;
`endif

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      n_q, n_d;
    logic [IDX_W-1:0]      mtx_q, mtx_d;          // matrix being fetched
    logic [IDX_W-1:0]      word_q, word_d;        // word within that matrix
    logic [IDX_W-1:0]      done_cnt_q, done_cnt_d;
    logic [MEM_ADDR_W-1:0] base_q, base_d;        // mtx_q * WORDS_PER_MTX
    logic [CNT_W-1:0]      credit_q, credit_d;

    logic                  accept;
    logic                  pop;
    logic                  last_word;
    logic                  ret_wr;
    row_tag_t              req_tag;
    row_tag_t              ret_tag;
    row_tag_t              head_tag;
    logic                  tag_empty;
    logic                  tag_full;
    logic [CNT_W-1:0]      tag_count;
    logic                  row_empty;
    logic                  row_full;
    logic [CNT_W-1:0]      row_count;
    logic [TAG_W+MEM_DATA_W-1:0] row_head;

    assign last_word  = (word_q == IDX_W'(WORDS_PER_MTX - 1));
    assign o_mem_addr = base_q + MEM_ADDR_W'(word_q);
    assign req_tag    = '{mtx: mtx_q, word: word_q, last: last_word};

    // A return with nothing outstanding (e.g. in flight across a reset) is dropped
    assign ret_wr = i_mem_dout_vld && !tag_empty;
    assign pop    = o_row_vld && i_row_rdy;

    // Tags queued in request order; returns are in order, so the head tag
    // always belongs to the next returning word.
    gsim_row_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_fifo (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_wr_en   (accept),
        .i_wr_data (req_tag),
        .i_rd_en   (i_mem_dout_vld),
        .o_rd_data (ret_tag),
        .o_full    (tag_full),
        .o_empty   (tag_empty),
        .o_count   (tag_count)
    );

    gsim_row_fifo #(
        .WIDTH (TAG_W + MEM_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_row_fifo (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_wr_en   (ret_wr),
        .i_wr_data ({ret_tag, i_mem_dout}),
        .i_rd_en   (i_row_rdy),
        .o_rd_data (row_head),
        .o_full    (row_full),
        .o_empty   (row_empty),
        .o_count   (row_count)
    );

    assign head_tag   = row_head[MEM_DATA_W +: TAG_W];
    assign o_row_vld  = !row_empty;
    assign o_row_data = row_head[MEM_DATA_W-1:0];
    assign o_row_idx  = head_tag.word;
    assign o_row_last = head_tag.last;
    assign o_mtx_idx  = head_tag.mtx;

    // Credit makes both FIFOs overflow-proof, so their status is informational
    logic unused_status;
    assign unused_status = ^{tag_full, tag_count, row_full, row_count};

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        mtx_d       = mtx_q;
        word_d      = word_q;
        base_d      = base_q;
        done_cnt_d  = done_cnt_q;
        credit_d    = credit_q;
        o_mem_rreq  = 1'b0;
        o_proc_done = 1'b0;
        accept      = 1'b0;

        if (state_q != ST_IDLE && i_mtx_done) begin
            done_cnt_d = done_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_module_en) begin
                    n_d        = i_matrix_num;
                    mtx_d      = '0;
                    word_d     = '0;
                    base_d     = '0;
                    done_cnt_d = '0;
                    state_d    = (i_matrix_num == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                o_mem_rreq = (credit_q != '0);
                accept     = o_mem_rreq && i_mem_rrdy;
                if (accept) begin
                    if (last_word) begin
                        word_d = '0;
                        base_d = base_q + MEM_ADDR_W'(WORDS_PER_MTX);
                        mtx_d  = mtx_q + 1'b1;
                        if (!PREFETCH || (mtx_q + 1'b1 == n_q)) begin
                            state_d = ST_WAIT_ENG;
                        end
                    end else begin
                        word_d = word_q + 1'b1;
                    end
                end
            end
            ST_WAIT_ENG: begin
                if (i_mtx_done) begin
                    if (done_cnt_q + 1'b1 == n_q) begin
                        state_d = ST_DONE;
                    end else if (mtx_q < n_q) begin
                        // With prefetch all matrices are already fetched here
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                o_proc_done = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        case ({accept, pop})
            2'b10:   credit_d = credit_q - 1'b1;
            2'b01:   credit_d = credit_q + 1'b1;
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            mtx_q      <= '0;
            word_q     <= '0;
            base_q     <= '0;
            done_cnt_q <= '0;
            credit_q   <= CNT_W'(FIFO_DEPTH);
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            mtx_q      <= mtx_d;
            word_q     <= word_d;
            base_q     <= base_d;
            done_cnt_q <= done_cnt_d;
            credit_q   <= credit_d;
        end
    end

endmodule

// File: tb/tb_gsim_fetch_sched.sv
// ----------------------------------------------------------------------------
// tb_gsim_fetch_sched
// Scoreboard bench for gsim_fetch_sched. start() queues the expected request
// addresses and expected rows; a memory model / monitor process pops and
// compares on every accepted request and every consumed row.
// Honours GSIM_PREFETCH_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_gsim_fetch_sched;

    localparam int FIFO_DEPTH = 4;
    localparam int LAT        = 2;
    localparam int WPM        = 17;

    logic         i_clk = 1'b0;
    logic         i_reset = 1'b1;
    logic         i_module_en = 1'b0;
    logic [4:0]   i_matrix_num = '0;
    logic         o_proc_done;
    logic         o_mem_rreq;
    logic [9:0]   o_mem_addr;
    logic         i_mem_rrdy = 1'b0;
    logic [255:0] i_mem_dout = '0;
    logic         i_mem_dout_vld = 1'b0;
    logic         o_row_vld;
    logic [255:0] o_row_data;
    logic [4:0]   o_row_idx;
    logic         o_row_last;
    logic [4:0]   o_mtx_idx;
    logic         i_row_rdy = 1'b0;
    logic         i_mtx_done = 1'b0;

    gsim_fetch_sched #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_module_en    (i_module_en),
        .i_matrix_num   (i_matrix_num),
        .o_proc_done    (o_proc_done),
        .o_mem_rreq     (o_mem_rreq),
        .o_mem_addr     (o_mem_addr),
        .i_mem_rrdy     (i_mem_rrdy),
        .i_mem_dout     (i_mem_dout),
        .i_mem_dout_vld (i_mem_dout_vld),
        .o_row_vld      (o_row_vld),
        .o_row_data     (o_row_data),
        .o_row_idx      (o_row_idx),
        .o_row_last     (o_row_last),
        .o_mtx_idx      (o_mtx_idx),
        .i_row_rdy      (i_row_rdy),
        .i_mtx_done     (i_mtx_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [255:0] data;
        logic [4:0]   idx;
        logic [4:0]   mtx;
        logic         last;
    } row_t;

    row_t exp_rows[$];
    int   exp_addr[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc_cnt = 0;
    int popped  = 0;
    int inflight = 0;
    int acc_cycle [1024];

    logic rrdy_level = 1'b1;
    logic rrdy_rand  = 1'b0;
    logic row_level  = 1'b1;
    logic row_rand   = 1'b0;

    function automatic logic [255:0] mem_word(input int a);
        logic [255:0] w;
        for (int k = 0; k < 8; k++) begin
            w[k*32 +: 32] = 32'hA500_0000 | (32'(a) << 8) | 32'(k);
        end
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk256(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Queue expectations, then pulse start for one cycle
    task automatic start(input int n);
        row_t r;
        for (int a = 0; a < n * WPM; a++) begin
            exp_addr.push_back(a);
            r.data = mem_word(a);
            r.idx  = 5'(a % WPM);
            r.mtx  = 5'(a / WPM);
            r.last = ((a % WPM) == WPM - 1);
            exp_rows.push_back(r);
        end
        i_matrix_num = 5'(n);
        i_module_en  = 1'b1;
        tick();
        i_module_en  = 1'b0;
    endtask

    task automatic wait_popped(input int target, input int budget, input string name);
        int i = 0;
        while (popped < target && i < budget) begin
            tick();
            i++;
        end
        n_tests++;
        if (popped < target) begin
            n_fail++;
            $display("FAIL %s: %0d rows consumed, expected %0d", name, popped, target);
        end
    endtask

    // Final i_mtx_done of a run: o_proc_done must follow for exactly one cycle
    task automatic finish_run(input string name);
        i_mtx_done = 1'b1;
        tick();
        i_mtx_done = 1'b0;
        chk({name, "_done_pulse"}, 32'(o_proc_done), 1);
        tick();
        chk({name, "_done_clear"}, 32'(o_proc_done), 0);
    endtask

    always @(posedge i_clk) cyc <= cyc + 1;

    // Ready drivers, applied just after the active edge
    initial begin
        forever begin
            @(posedge i_clk);
            #2;
            i_mem_rrdy = rrdy_rand ? 1'($urandom_range(0, 1)) : rrdy_level;
            i_row_rdy  = row_rand  ? 1'($urandom_range(0, 1)) : row_level;
        end
    end

    // Memory model, request checker and row scoreboard
    initial begin
        logic pipe_v [LAT];
        int   pipe_a [LAT];
        logic hold_v;
        int   hold_a;
        int   ea;
        row_t e;
        hold_v = 1'b0;
        hold_a = 0;
        for (int k = 0; k < LAT; k++) begin
            pipe_v[k] = 1'b0;
            pipe_a[k] = 0;
        end
        forever begin
            @(negedge i_clk);
            i_mem_dout_vld = pipe_v[LAT-1];
            i_mem_dout     = pipe_v[LAT-1] ? mem_word(pipe_a[LAT-1]) : '0;
            for (int k = LAT - 1; k > 0; k--) begin
                pipe_v[k] = pipe_v[k-1];
                pipe_a[k] = pipe_a[k-1];
            end
            pipe_v[0] = 1'b0;

            if (hold_v && !i_reset) begin
                chk("stall_rreq_held", 32'(o_mem_rreq), 1);
                chk("stall_addr_held", 32'(o_mem_addr), 32'(hold_a));
            end
            hold_v = !i_reset && o_mem_rreq && !i_mem_rrdy;
            hold_a = int'(o_mem_addr);

            if (!i_reset && o_mem_rreq && i_mem_rrdy) begin
                chk("credit_limit", 32'(inflight < FIFO_DEPTH), 1);
                if (exp_addr.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_req: addr %0d, expected no request", o_mem_addr);
                end else begin
                    ea = exp_addr.pop_front();
                    chk("req_addr", 32'(o_mem_addr), 32'(ea));
                end
                acc_cycle[o_mem_addr] = cyc;
                acc_cnt++;
                inflight++;
                pipe_v[0] = 1'b1;
                pipe_a[0] = int'(o_mem_addr);
            end

            if (!i_reset && o_row_vld && i_row_rdy) begin
                $display("[TB] row mtx=%0d idx=%0d last=%0d", o_mtx_idx, o_row_idx, o_row_last);
                if (exp_rows.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_row: mtx %0d idx %0d, expected no row", o_mtx_idx, o_row_idx);
                end else begin
                    e = exp_rows.pop_front();
                    chk256("row_data", o_row_data, e.data);
                    chk("row_idx",  32'(o_row_idx),  32'(e.idx));
                    chk("row_mtx",  32'(o_mtx_idx),  32'(e.mtx));
                    chk("row_last", 32'(o_row_last), 32'(e.last));
                end
                popped++;
                inflight--;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int p0;

        // ---- reset values ----
        #12;
        chk("rst_proc_done", 32'(o_proc_done), 0);
        chk("rst_rreq",      32'(o_mem_rreq),  0);
        chk("rst_addr",      32'(o_mem_addr),  0);
        chk("rst_row_vld",   32'(o_row_vld),   0);
        chk256("rst_row_data", o_row_data, '0);
        chk("rst_row_idx",   32'(o_row_idx),   0);
        chk("rst_row_last",  32'(o_row_last),  0);
        chk("rst_mtx_idx",   32'(o_mtx_idx),   0);
        tick();
        tick();
        i_reset = 1'b0;
        tick();

        // ---- N=1, full throughput ----
        $display("[TB] test: single matrix");
        p0 = popped;
        start(1);
        chk("first_rreq", 32'(o_mem_rreq), 1);
        chk("first_addr", 32'(o_mem_addr), 0);
        wait_popped(p0 + WPM, 200, "n1_rows");
        finish_run("n1");

        // ---- N=3, serial or prefetch ----
        $display("[TB] test: three matrices");
        p0 = popped;
        a0 = acc_cnt;
        start(3);
        for (int m = 0; m < 3; m++) begin
            wait_popped(p0 + WPM * (m + 1), 300, "n3_rows");
`ifndef GSIM_PREFETCH_EN
            repeat (4) tick();
            chk("serial_rreq_idle", 32'(o_mem_rreq), 0);
            chk("serial_acc_count", 32'(acc_cnt - a0), 32'(WPM * (m + 1)));
`endif
            if (m < 2) begin
                i_mtx_done = 1'b1;
                tick();
                i_mtx_done = 1'b0;
                chk("n3_no_early_done", 32'(o_proc_done), 0);
`ifndef GSIM_PREFETCH_EN
                chk("serial_next_rreq", 32'(o_mem_rreq), 1);
                chk("serial_next_addr", 32'(o_mem_addr), 32'(WPM * (m + 1)));
`endif
            end else begin
                finish_run("n3");
            end
        end
`ifdef GSIM_PREFETCH_EN
        chk("prefetch_gap_16_17", 32'(acc_cycle[17] - acc_cycle[16]), 1);
        chk("prefetch_gap_33_34", 32'(acc_cycle[34] - acc_cycle[33]), 1);
`endif

        // ---- back-pressure: credit limit ----
        $display("[TB] test: back-pressure");
        p0 = popped;
        a0 = acc_cnt;
        row_level = 1'b0;
        tick();
        start(1);
        repeat (12) tick();
        chk("bp_acc_count", 32'(acc_cnt - a0), 4);
        chk("bp_rreq_low",  32'(o_mem_rreq), 0);
        row_level = 1'b1;
        tick();
        row_level = 1'b0;
        repeat (6) tick();
        chk("bp_one_more", 32'(acc_cnt - a0), 5);
        row_level = 1'b1;
        wait_popped(p0 + WPM, 200, "bp_rows");
        finish_run("bp");

        // ---- random stalls on both ready inputs ----
        $display("[TB] test: random stalls");
        p0 = popped;
        rrdy_rand = 1'b1;
        row_rand  = 1'b1;
        start(1);
        wait_popped(p0 + WPM, 1000, "rand_rows");
        rrdy_rand = 1'b0;
        row_rand  = 1'b0;
        finish_run("rand");

        // ---- N=0 ----
        $display("[TB] test: zero matrices");
        a0 = acc_cnt;
        start(0);
        chk("n0_done_pulse", 32'(o_proc_done), 1);
        tick();
        chk("n0_done_clear", 32'(o_proc_done), 0);
        repeat (3) tick();
        chk("n0_no_requests", 32'(acc_cnt - a0), 0);

        // ---- reset mid-FETCH with returns still in flight ----
        $display("[TB] test: reset mid-fetch");
        row_level = 1'b0;
        tick();
        start(2);
        repeat (4) tick();
        chk("prerst_row_vld", 32'(o_row_vld), 1);
        i_reset = 1'b1;
        #1;
        chk("mid_rst_rreq",      32'(o_mem_rreq),  0);
        chk("mid_rst_addr",      32'(o_mem_addr),  0);
        chk("mid_rst_row_vld",   32'(o_row_vld),   0);
        chk256("mid_rst_row_data", o_row_data, '0);
        chk("mid_rst_row_idx",   32'(o_row_idx),   0);
        chk("mid_rst_mtx_idx",   32'(o_mtx_idx),   0);
        chk("mid_rst_proc_done", 32'(o_proc_done), 0);
        exp_rows.delete();
        exp_addr.delete();
        inflight = 0;
        #1;
        i_reset = 1'b0;
        row_level = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("late_return_dropped", 32'(o_row_vld), 0);
        end
        chk("post_rst_idle", 32'(o_mem_rreq), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
